// File: rtl/mem_pkg.sv
// Shared types, default widths and address helper for the latency memory model.
package mem_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DEPTH_LOG2 = 10;
  localparam int unsigned DEF_LATENCY    = 2;
  localparam int unsigned DEF_RESP_Q     = 2;

  // Byte address to word index; bits above the array size wrap.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned depth_log2);
    logic [31:0] mask;
    mask = (32'd1 << depth_log2) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Response queue with a registered head word, wrap-around pointers and explicit count.
module resp_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_head;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty  = (r_cnt == '0);
  assign o_full   = (r_cnt == CNT_W'(DEPTH));
  assign o_head   = r_head;
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);
  assign w_rd_nxt = ptr_inc(r_rd_ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      // Head follows the push when the queue is (or becomes) otherwise empty.
      if (w_push && (o_empty || (w_pop && r_cnt == CNT_W'(1)))) begin
        r_head <= i_push_data;
      end else if (w_pop && r_cnt > CNT_W'(1)) begin
        r_head <= r_mem[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/lat_mem.sv
// Word-addressed memory with fixed read latency, credit-limited reads and in-order responses.
module lat_mem
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned LATENCY    = DEF_LATENCY,
  parameter int unsigned RESP_Q     = DEF_RESP_Q
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = $clog2(RESP_Q + 1);

  logic [DATA_W-1:0]     r_mem [WORDS];
  logic [CNT_W-1:0]      r_out_cnt;
  logic [DEPTH_LOG2-1:0] w_idx;
  mem_op_e               w_op;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_consume;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  w_push;
  logic [DATA_W-1:0]     w_push_data;
  logic                  w_full;
  logic                  w_empty;

  assign w_idx     = DEPTH_LOG2'(word_index(32'(req_addr), DEPTH_LOG2));
  assign w_op      = mem_op_e'(req_op);
  assign req_ready = !reset && (r_out_cnt < CNT_W'(RESP_Q));
  assign w_rd_acc  = req_valid && req_ready && (w_op == MEM_READ);
  assign w_wr_acc  = req_valid && req_ready && (w_op == MEM_WRITE);
  assign w_consume = resp_valid && resp_ready;
  assign w_rd_data = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_idx] <= req_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_cnt <= '0;
    end else if (w_rd_acc && !w_consume) begin
      r_out_cnt <= r_out_cnt + CNT_W'(1);
    end else if (!w_rd_acc && w_consume) begin
      r_out_cnt <= r_out_cnt - CNT_W'(1);
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign w_push      = w_rd_acc;
    assign w_push_data = w_rd_data;
  end else begin : g_pipe
    localparam int unsigned STAGES = LATENCY - 1;
    logic [STAGES-1:0] r_pv;
    logic [DATA_W-1:0] r_pd [STAGES];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pv <= '0;
        for (int i = 0; i < STAGES; i++) r_pd[i] <= '0;
      end else begin
        r_pv[0] <= w_rd_acc;
        r_pd[0] <= w_rd_data;
        for (int i = 1; i < STAGES; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_pd[i] <= r_pd[i-1];
        end
      end
    end

    assign w_push      = r_pv[STAGES-1];
    assign w_push_data = r_pd[STAGES-1];
  end

  resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_Q)
  ) u_resp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (resp_ready),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (resp_data)
  );

  assign resp_valid = !w_empty;

  // The credit check guarantees a push never meets a full queue without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
                                   !(w_push && w_full && !w_consume));

endmodule
